// File: rtl/zap_decode_mem_fsm.sv
// LDM/STM expansion stage: sequences block transfers into single LDR/STR
// micro-ops plus an optional base-writeback ADD/SUB, stalling fetch meanwhile.
module zap_decode_mem_fsm (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_fiq,
  input  logic        i_irq,
  input  logic        i_clear_from_writeback,
  input  logic        i_data_stall,
  input  logic        i_clear_from_alu,
  input  logic        i_stall_from_shifter,
  input  logic        i_stall_from_issue,
  input  logic        i_stall_from_decode,
  input  logic [34:0] i_instruction,
  input  logic        i_instruction_valid,
  output logic [34:0] o_instruction,
  output logic        o_instruction_valid,
  output logic        o_stall_from_decode,
  output logic        o_fiq,
  output logic        o_irq
);

  typedef enum logic [1:0] {IDLE, MEM, WB} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cond_q, cond_nxt, rn_q, rn_nxt;
  logic        p_q, p_nxt, u_q, u_nxt, l_q, l_nxt, wb_q, wb_nxt;
  logic [15:0] list_q, list_nxt;
  logic [4:0]  idx_q, idx_nxt, n_q, n_nxt;

  logic [15:0] in_list, in_rest, cur_rest;
  logic [4:0]  in_n;
  logic        expandable, in_wb, go_idle, hold;

  function automatic logic [3:0] lowest_reg(input logic [15:0] l);
    lowest_reg = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (l[i]) lowest_reg = 4'(i);
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] l);
    popcount16 = 5'd0;
    for (int i = 0; i < 16; i++)
      popcount16 = popcount16 + {4'd0, l[i]};
  endfunction

  // Offsets span -64..+64, so an 8-bit signed sum is enough before taking |off|.
  function automatic logic [31:0] mem_uop(input logic [3:0] cond, input logic p,
                                          input logic u, input logic l,
                                          input logic [3:0] rn, input logic [3:0] rk,
                                          input logic [4:0] k, input logic [4:0] n);
    logic signed [7:0] k4, n4, base, off;
    logic [7:0] mag;
    k4 = {1'b0, k, 2'b00};
    n4 = {1'b0, n, 2'b00};
    if (u) base = p ? 8'sd4 : 8'sd0;
    else   base = p ? -n4 : (8'sd4 - n4);
    off = k4 + base;
    mag = off[7] ? -off : off;
    mem_uop = {cond, 3'b010, 1'b1, ~off[7], 1'b0, 1'b0, l, rn, rk, 4'h0, mag};
  endfunction

  always_comb begin
    in_list    = i_instruction[15:0];
    in_rest    = in_list & (in_list - 16'd1);
    cur_rest   = list_q & (list_q - 16'd1);
    in_n       = popcount16(in_list);
    expandable = i_instruction_valid && (i_instruction[27:25] == 3'b100) &&
                 !i_instruction[22] && (|in_list);
    in_wb      = i_instruction[21] && !(i_instruction[20] && in_list[i_instruction[19:16]]);
  end

  always_comb begin
    o_instruction       = i_instruction;
    o_instruction_valid = i_instruction_valid;
    o_stall_from_decode = 1'b0;
    o_irq               = i_irq;
    o_fiq               = i_fiq;
    case (state)
      IDLE: begin
        if (expandable) begin
          o_instruction       = {3'b000, mem_uop(i_instruction[31:28], i_instruction[24],
                                 i_instruction[23], i_instruction[20], i_instruction[19:16],
                                 lowest_reg(in_list), 5'd0, in_n)};
          o_instruction_valid = 1'b1;
          o_stall_from_decode = (|in_rest) || in_wb;
          o_irq               = 1'b0;
          o_fiq               = 1'b0;
        end
      end
      MEM: begin
        o_instruction       = {3'b000, mem_uop(cond_q, p_q, u_q, l_q, rn_q,
                               lowest_reg(list_q), idx_q, n_q)};
        o_instruction_valid = 1'b1;
        o_stall_from_decode = (|cur_rest) || wb_q;
        o_irq               = 1'b0;
        o_fiq               = 1'b0;
      end
      default: begin
        o_instruction       = {3'b000, cond_q, (u_q ? 8'h28 : 8'h24), rn_q, rn_q, 4'h0,
                               {1'b0, n_q, 2'b00}};
        o_instruction_valid = 1'b1;
        o_irq               = 1'b0;
        o_fiq               = 1'b0;
      end
    endcase
  end

  // Writeback flush beats every hold; a data stall beats the ALU flush.
  always_comb begin
    state_nxt = state;
    cond_nxt  = cond_q;
    rn_nxt    = rn_q;
    p_nxt     = p_q;
    u_nxt     = u_q;
    l_nxt     = l_q;
    wb_nxt    = wb_q;
    list_nxt  = list_q;
    idx_nxt   = idx_q;
    n_nxt     = n_q;
    go_idle   = i_clear_from_writeback || (!i_data_stall && i_clear_from_alu);
    hold      = !i_clear_from_writeback && (i_data_stall || (!i_clear_from_alu &&
                (i_stall_from_shifter || i_stall_from_issue || i_stall_from_decode)));
    if (go_idle) begin
      state_nxt = IDLE;
      list_nxt  = 16'd0;
      idx_nxt   = 5'd0;
    end else if (!hold) begin
      case (state)
        IDLE: begin
          if (expandable) begin
            cond_nxt  = i_instruction[31:28];
            p_nxt     = i_instruction[24];
            u_nxt     = i_instruction[23];
            l_nxt     = i_instruction[20];
            rn_nxt    = i_instruction[19:16];
            wb_nxt    = in_wb;
            n_nxt     = in_n;
            list_nxt  = in_rest;
            idx_nxt   = (|in_rest) ? 5'd1 : 5'd0;
            state_nxt = (|in_rest) ? MEM : (in_wb ? WB : IDLE);
          end
        end
        MEM: begin
          list_nxt = cur_rest;
          idx_nxt  = idx_q + 5'd1;
          if (!(|cur_rest)) begin
            idx_nxt   = 5'd0;
            state_nxt = wb_q ? WB : IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= IDLE;
      cond_q <= 4'd0;
      rn_q   <= 4'd0;
      p_q    <= 1'b0;
      u_q    <= 1'b0;
      l_q    <= 1'b0;
      wb_q   <= 1'b0;
      list_q <= 16'd0;
      idx_q  <= 5'd0;
      n_q    <= 5'd0;
    end else begin
      state  <= state_nxt;
      cond_q <= cond_nxt;
      rn_q   <= rn_nxt;
      p_q    <= p_nxt;
      u_q    <= u_nxt;
      l_q    <= l_nxt;
      wb_q   <= wb_nxt;
      list_q <= list_nxt;
      idx_q  <= idx_nxt;
      n_q    <= n_nxt;
    end
  end

endmodule
